bram_capture_ctrl: RTL

- Downstream consumer of the sinc rising-edge pulse (`sinc_edge`).
- On each accepted edge, skips `DELAY` ADC samples, then writes `NUM_SAMPLES` consecutive valid ADC samples into a dual-bank (ping-pong) BRAM.
- When a frame is complete, it signals the bank that was just filled to the readout side (PS/DMA) and switches capture to the other bank.
- Sits in the receiver chain between the edge detector and the sample BRAM.

---
 rtl/bram_capture_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bram_capture_ctrl.sv
// Sinc-triggered ADC frame capture into a ping-pong BRAM.
// Skips DELAY valid samples after an edge, then writes NUM_SAMPLES samples to one bank.
module bram_capture_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int NUM_SAMPLES = 1000,
    parameter int DELAY       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sinc_edge,
    input  logic              enable,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              clr_overrun,
    output logic              bram_we,
    output logic [ADDR_W:0]   bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              busy,
    output logic              done,
    output logic              ready_bank,
    output logic [15:0]       frame_count,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DELAY,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [15:0] DLY_LAST =
        (DELAY == 0) ? 16'd0 : 16'(DELAY - 1);
    localparam state_t START = (DELAY == 0) ? CAPTURE : WAIT_DELAY;

    state_t            state;
    state_t            state_n;
    logic [15:0]       dly_cnt;
    logic [15:0]       dly_n;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_n;
    logic              bank;
    logic              wr_n;
    logic              fin;

    always_comb begin
        state_n = state;
        dly_n   = dly_cnt;
        idx_n   = idx;
        wr_n    = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sinc_edge && enable) begin
                    state_n = START;
                    dly_n   = '0;
                    idx_n   = '0;
                end
            end
            WAIT_DELAY: begin
                if (!enable) begin
                    state_n = IDLE;
                    dly_n   = '0;
                end else if (adc_valid) begin
                    // the DELAY-th valid sample is dropped, not written
                    if (dly_cnt == DLY_LAST) begin
                        state_n = CAPTURE;
                        dly_n   = '0;
                    end else begin
                        dly_n = dly_cnt + 16'd1;
                    end
                end
            end
            CAPTURE: begin
                if (!enable) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (adc_valid) begin
                    wr_n = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_n = DONE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                fin     = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dly_cnt     <= '0;
            idx         <= '0;
            bank        <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ready_bank  <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            state   <= state_n;
            dly_cnt <= dly_n;
            idx     <= idx_n;
            bram_we <= wr_n;
            busy    <= (state_n != IDLE);
            done    <= fin;
            if (wr_n) begin
                bram_addr <= {bank, idx};
                bram_din  <= adc_data;
            end
            if (fin) begin
                ready_bank  <= bank;
                bank        <= ~bank;
                frame_count <= frame_count + 16'd1;
            end
            // a late edge takes priority over a clear in the same cycle
            if (sinc_edge && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
